// File: rtl/snowflake_collect_if.sv
// Indexed read port into the snowflake position store.
// Data returns one cycle after the index is presented.
interface snowflake_collect_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
) ();
  logic [3:0]     flake_idx;
  logic [X_W-1:0] flake_x;
  logic [Y_W-1:0] flake_y;

  modport master (output flake_idx, input flake_x, input flake_y);
  modport slave  (input flake_idx, output flake_x, output flake_y);
endinterface

// File: rtl/snowflake_collect.sv
// Per-frame scan of all snowflake positions against the player hitbox,
// accumulating a sticky collected-flake vector with collection/level-clear pulses.
module snowflake_collect #(
  parameter int N_FLAKES = 15,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int HIT_W    = 16,
  parameter int HIT_H    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 clear_all,
  input  logic [X_W-1:0]       player_x,
  input  logic [Y_W-1:0]       player_y,
  snowflake_collect_if.master  store,
  output logic [N_FLAKES-1:0]  snowf_get,
  output logic                 collect_pulse,
  output logic [3:0]           collect_idx,
  output logic                 scan_done,
  output logic                 level_clear,
  output logic                 busy
);

  localparam logic signed [X_W:0] THR_X = (X_W+1)'(HIT_W);
  localparam logic signed [Y_W:0] THR_Y = (Y_W+1)'(HIT_H);
  localparam logic [3:0]          LAST  = 4'(N_FLAKES - 1);

  typedef enum logic [1:0] {IDLE, REQ, CMP, DONE} state_t;

  state_t              state;
  logic [3:0]          idx;
  logic                cleared;
  logic [X_W-1:0]      px;
  logic [Y_W-1:0]      py;
  logic                hit;
  logic                new_hit;
  logic [N_FLAKES-1:0] set_mask;
  logic [N_FLAKES-1:0] snow_next;

  // One extra bit of signed headroom keeps the difference from wrapping.
  function automatic logic close_x(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
    logic signed [X_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d < THR_X;
  endfunction

  function automatic logic close_y(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
    logic signed [Y_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d < THR_Y;
  endfunction

  always_comb begin
    hit           = close_x(px, store.flake_x) && close_y(py, store.flake_y);
    new_hit       = hit && !snowf_get[idx];
    set_mask      = '0;
    set_mask[idx] = hit;
    snow_next     = snowf_get | set_mask;
  end

  // Player position is data: captured at scan start, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && frame_tick) begin
      px <= player_x;
      py <= player_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      store.flake_idx <= '0;
      busy            <= 1'b0;
      snowf_get       <= '0;
      collect_pulse   <= 1'b0;
      collect_idx     <= '0;
      scan_done       <= 1'b0;
      level_clear     <= 1'b0;
      cleared         <= 1'b0;
    end else if (clear_all) begin
      state         <= IDLE;
      busy          <= 1'b0;
      snowf_get     <= '0;
      collect_pulse <= 1'b0;
      scan_done     <= 1'b0;
      level_clear   <= 1'b0;
      cleared       <= 1'b0;
    end else begin
      collect_pulse <= 1'b0;
      scan_done     <= 1'b0;
      level_clear   <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            idx             <= '0;
            store.flake_idx <= '0;
            busy            <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: state <= CMP;
        CMP: begin
          if (new_hit) begin
            snowf_get     <= snow_next;
            collect_pulse <= 1'b1;
            collect_idx   <= idx;
          end
          if (idx == LAST) begin
            state     <= DONE;
            scan_done <= 1'b1;
            // Judge level clear on the vector including this cycle's hit.
            if ((&snow_next) && !cleared) begin
              level_clear <= 1'b1;
              cleared     <= 1'b1;
            end
          end else begin
            idx             <= idx + 4'd1;
            store.flake_idx <= idx + 4'd1;
            state           <= REQ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snowflake_collect.sv
// Scoreboard bench: stimulus pushes expected collect/done events, a monitor pops and compares them.
module tb_snowflake_collect;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        clear_all = 1'b0;
  logic [9:0]  player_x = 10'd100;
  logic [8:0]  player_y = 9'd100;
  logic [14:0] snowf_get;
  logic        collect_pulse;
  logic [3:0]  collect_idx;
  logic        scan_done;
  logic        level_clear;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] fx_mem [16];
  logic [8:0] fy_mem [16];

  typedef struct { int cyc; int idx; logic [14:0] vec; } col_t;
  typedef struct { int cyc; logic lc; } done_t;
  col_t  col_q [$];
  done_t done_q [$];
  col_t  mc;
  done_t md;

  snowflake_collect_if #(.X_W(10), .Y_W(9)) sif ();

  snowflake_collect dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .clear_all(clear_all),
    .player_x(player_x), .player_y(player_y), .store(sif.master),
    .snowf_get(snowf_get), .collect_pulse(collect_pulse), .collect_idx(collect_idx),
    .scan_done(scan_done), .level_clear(level_clear), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Position store model with one-cycle read latency.
  always @(posedge clk) begin
    sif.flake_x <= fx_mem[sif.flake_idx];
    sif.flake_y <= fy_mem[sif.flake_idx];
  end

  always @(negedge clk) begin
    if (collect_pulse) begin
      checks++;
      if (col_q.size() == 0) begin
        errors++;
        $display("FAIL collect_unexpected: cyc=%0d idx=%0d vec=%h, none expected", cyc, collect_idx, snowf_get);
      end else begin
        mc = col_q.pop_front();
        if (cyc != mc.cyc || int'(collect_idx) != mc.idx || snowf_get !== mc.vec) begin
          errors++;
          $display("FAIL collect: got cyc=%0d idx=%0d vec=%h, want cyc=%0d idx=%0d vec=%h",
                   cyc, collect_idx, snowf_get, mc.cyc, mc.idx, mc.vec);
        end
      end
    end
    if (scan_done || level_clear) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: cyc=%0d scan_done=%b level_clear=%b", cyc, scan_done, level_clear);
      end else begin
        md = done_q.pop_front();
        if (cyc != md.cyc || scan_done !== 1'b1 || level_clear !== md.lc) begin
          errors++;
          $display("FAIL done: got cyc=%0d sd=%b lc=%b, want cyc=%0d sd=1 lc=%b",
                   cyc, scan_done, level_clear, md.cyc, md.lc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start_frame(output int t);
    @(negedge clk);
    frame_tick = 1'b1;
    t = cyc;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic set_all(input logic [9:0] x, input logic [8:0] y);
    for (int i = 0; i < 16; i++) begin
      fx_mem[i] = x;
      fy_mem[i] = y;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
  endtask

  task automatic push_col(input int c, input int i, input logic [14:0] v);
    col_q.push_back('{cyc: c, idx: i, vec: v});
  endtask

  task automatic push_done(input int c, input logic lc);
    done_q.push_back('{cyc: c, lc: lc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cyc=%0d, want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    set_all(10'd300, 9'd200);
    repeat (3) @(negedge clk);
    chk("reset_snowf", 32'(snowf_get), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_flake_idx", 32'(sif.flake_idx), 32'h0);
    chk("reset_pulses", {29'd0, collect_pulse, scan_done, level_clear}, 32'h0);
    rst = 1'b0;

    // All flakes far away: no collections.
    start_frame(t);
    push_done(t + 31, 1'b0);
    chk("t1_busy_start", 32'(busy), 32'h1);
    chk("t1_idx0", 32'(sif.flake_idx), 32'h0);
    wait_cyc(t + 3);
    chk("t1_idx1", 32'(sif.flake_idx), 32'h1);
    wait_cyc(t + 31);
    chk("t1_busy_done", 32'(busy), 32'h1);
    wait_cyc(t + 32);
    chk("t1_busy_end", 32'(busy), 32'h0);
    chk("t1_snowf", 32'(snowf_get), 32'h0);

    // Single flake 3 within the hitbox, then a repeat frame.
    fx_mem[3] = 10'd110; fy_mem[3] = 9'd105;
    start_frame(t);
    push_col(t + 9, 3, 15'h0008);
    push_done(t + 31, 1'b0);
    wait_cyc(t + 8);
    chk("t2_before", 32'(snowf_get), 32'h0);
    wait_cyc(t + 9);
    chk("t2_bit3", 32'(snowf_get), 32'h0008);
    wait_cyc(t + 33);
    start_frame(t);
    push_done(t + 31, 1'b0);
    wait_cyc(t + 33);
    chk("t2_sticky", 32'(snowf_get), 32'h0008);

    // Threshold edges.
    pulse_clear();
    chk("clear_idle", 32'(snowf_get), 32'h0);
    set_all(10'd300, 9'd200);
    fx_mem[0] = 10'd116; fy_mem[0] = 9'd100;
    fx_mem[1] = 10'd115; fy_mem[1] = 9'd100;
    fx_mem[2] = 10'd84;  fy_mem[2] = 9'd100;
    fx_mem[5] = 10'd100; fy_mem[5] = 9'd116;
    fx_mem[6] = 10'd100; fy_mem[6] = 9'd84;
    fx_mem[7] = 10'd85;  fy_mem[7] = 9'd115;
    start_frame(t);
    push_col(t + 5, 1, 15'h0002);
    push_col(t + 17, 7, 15'h0082);
    push_done(t + 31, 1'b0);
    wait_cyc(t + 33);
    chk("t3_snowf", 32'(snowf_get), 32'h0082);

    // Everything collected in one frame, then a repeat frame.
    pulse_clear();
    set_all(10'd100, 9'd100);
    start_frame(t);
    for (int k = 0; k < 15; k++) push_col(t + 3 + 2 * k, k, 15'((32'd1 << (k + 1)) - 1));
    push_done(t + 31, 1'b1);
    wait_cyc(t + 33);
    chk("t4_all", 32'(snowf_get), 32'h7fff);
    start_frame(t);
    push_done(t + 31, 1'b0);
    wait_cyc(t + 33);
    chk("t4_repeat", 32'(snowf_get), 32'h7fff);

    // clear_all mid-scan, then a fresh scan from index 0.
    pulse_clear();
    start_frame(t);
    for (int k = 0; k < 4; k++) push_col(t + 3 + 2 * k, k, 15'((32'd1 << (k + 1)) - 1));
    wait_cyc(t + 10);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    chk("t5_snowf", 32'(snowf_get), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    wait_cyc(t + 14);
    start_frame(t);
    for (int k = 0; k < 15; k++) push_col(t + 3 + 2 * k, k, 15'((32'd1 << (k + 1)) - 1));
    push_done(t + 31, 1'b1);
    wait_cyc(t + 33);
    chk("t5_all", 32'(snowf_get), 32'h7fff);

    // frame_tick while busy is dropped.
    start_frame(t);
    push_done(t + 31, 1'b0);
    wait_cyc(t + 5);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_cyc(t + 33);
    chk("t6_no_requeue", 32'(busy), 32'h0);

    // rst mid-scan.
    start_frame(t);
    wait_cyc(t + 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_snowf", 32'(snowf_get), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_idx", 32'(sif.flake_idx), 32'h0);
    chk("t6_rst_cidx", 32'(collect_idx), 32'h0);
    wait_cyc(t + 40);
    chk("t6_idle", 32'(busy), 32'h0);

    chk("col_q_empty", 32'(col_q.size()), 32'h0);
    chk("done_q_empty", 32'(done_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
